lap_monitor: RTL

LAP_MONITOR -- requirements
Module: lap_monitor

---
 rtl/lap_monitor_pkg.sv | 18 +
 rtl/lap_monitor_sat_counter.sv | 30 +++
 rtl/lap_monitor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lap_monitor_pkg.sv
// lap_monitor_pkg
//   Shared definitions for the lap monitor: default widths and the FSM
//   state type with its fixed encodings (encoding 3 is unused and is
//   treated as IDLE by the monitor).
package lap_monitor_pkg;

    localparam int W_DEF  = 10;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] STATE_UNUSED = 2'd3;

endpackage

// File: rtl/lap_monitor_sat_counter.sv
// sat_counter
//   Saturating up-counter used for the completed-lap count. Holds at
//   all-ones instead of wrapping.
//   Ports:
//     clk   - rising-edge clock
//     rst   - asynchronous active-low reset, clears count
//     clr   - synchronous clear, takes priority over inc
//     inc   - increment request for this edge
//     count - current count value
module sat_counter #(
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [LW-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {LW{1'b1}})) begin
            count <= count + LW'(1);
        end
    end

endmodule

// File: rtl/lap_monitor.sv
// lap_monitor
//   Watches an upstream wrap counter (counts 1..n, advanced by step) and
//   reports completed laps plus sticky error flags. The count sampled on an
//   edge is checked against what the previous edge predicts, so every flag
//   and the lap pulse are registered on the very edge that samples the
//   offending or completing value.
//   Ports:
//     clk       - rising-edge clock
//     rst       - asynchronous active-low reset
//     step      - upstream advance enable, sampled with c
//     c         - upstream count value
//     n         - upstream wrap bound
//     clr       - synchronous clear of counters, flags and state
//     lap_done  - one-cycle pulse per completed lap
//     lap_count - completed laps, saturating
//     err_bound - sticky, c exceeded n
//     err_seq   - sticky, illegal count transition or n change
//     bad_c     - c captured on the edge that entered ERROR
//     state     - FSM state encoding (IDLE=0, RUN=1, ERROR=2)
module lap_monitor
    import lap_monitor_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [W-1:0]  c,
    input  logic [W-1:0]  n,
    input  logic          clr,
    output logic          lap_done,
    output logic [LW-1:0] lap_count,
    output logic          err_bound,
    output logic          err_seq,
    output logic [W-1:0]  bad_c,
    output logic [1:0]    state
);

    state_t         state_q;
    state_t         state_d;
    state_t         st_eff;
    logic [W-1:0]   prev_c;
    logic [W-1:0]   prev_n;
    logic           prev_step;
    logic           prev_valid;
    logic [W-1:0]   exp_c;
    logic           seq_err;
    logic           bound_err;
    logic           any_err;
    logic           lap_hit;

    assign state = state_q;

    always_comb begin
        // The unused encoding behaves exactly like IDLE.
        st_eff = IDLE;
        if (state_q == RUN || state_q == ERROR) begin
            st_eff = state_q;
        end

        // Value the upstream counter must present on this edge.
        exp_c = prev_c;
        if (prev_step) begin
            exp_c = (prev_c == prev_n) ? W'(1) : prev_c + W'(1);
        end

        seq_err   = prev_valid && (st_eff == RUN) &&
                    ((c != exp_c) || (n != prev_n));
        bound_err = (st_eff != ERROR) && (c > n);
        any_err   = seq_err || bound_err;

        // An error on the same edge suppresses the lap.
        lap_hit   = (st_eff == RUN) && prev_step && (prev_c == prev_n) &&
                    (c == W'(1)) && !any_err;

        state_d = st_eff;
        case (st_eff)
            IDLE: begin
                if (any_err) begin
                    state_d = ERROR;
                end else if (step) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (any_err) begin
                    state_d = ERROR;
                end
            end
            default: begin
                state_d = st_eff;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            prev_c     <= '0;
            prev_n     <= '0;
            prev_step  <= 1'b0;
            prev_valid <= 1'b0;
            lap_done   <= 1'b0;
            err_bound  <= 1'b0;
            err_seq    <= 1'b0;
            bad_c      <= '0;
        end else if (clr) begin
            // clr beats any error raised on the same edge.
            state_q    <= IDLE;
            prev_c     <= '0;
            prev_n     <= '0;
            prev_step  <= 1'b0;
            prev_valid <= 1'b0;
            lap_done   <= 1'b0;
            err_bound  <= 1'b0;
            err_seq    <= 1'b0;
            bad_c      <= '0;
        end else begin
            state_q    <= state_d;
            prev_c     <= c;
            prev_n     <= n;
            prev_step  <= step;
            prev_valid <= 1'b1;
            lap_done   <= lap_hit;
            err_bound  <= err_bound | bound_err;
            err_seq    <= err_seq | seq_err;
            // Capture only on the edge that enters ERROR.
            if (st_eff != ERROR && any_err) begin
                bad_c <= c;
            end
        end
    end

    sat_counter #(
        .LW (LW)
    ) u_lap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (lap_hit),
        .count (lap_count)
    );

endmodule
